// File: rtl/reg_writeback_sequencer.sv
// -----------------------------------------------------------------------------
// reg_writeback_sequencer
//
// Write-side master for the 32x32 integer register file. Writeback requests
// from the execute/load paths are buffered in a small FIFO and replayed to the
// register file as a registered wa/wd pair followed one cycle later by a
// one-cycle w_en strobe. The file commits on the rising edge of w_en, so wa/wd
// are always stable for a full cycle before the strobe. One write per 2 cycles.
//
// Ports
//   clk        in   single clock, all state updates on posedge
//   rst        in   synchronous active-high reset
//   req_valid  in   writeback request valid
//   req_ready  out  room in the FIFO (registered count < DEPTH, not in reset)
//   req_addr   in   destination register index (index 0 is accepted and dropped)
//   req_data   in   value to write
//   wa         out  register file write address (registered)
//   wd         out  register file write data (registered)
//   w_en       out  register file write strobe (registered, one cycle wide)
//   count      out  entries queued but not yet loaded into wa/wd
//   busy       out  sequencer active or FIFO non-empty
//
// Optional feature, enabled by defining WB_BYPASS_EN:
//   byp_addr   in   lookup address for forwarding of not-yet-committed writes
//   byp_hit    out  a pending write to byp_addr exists
//   byp_data   out  data of the youngest pending write to byp_addr (0 on miss)
// -----------------------------------------------------------------------------
module reg_writeback_sequencer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_data,
    output logic [ADDR_W-1:0]        wa,
    output logic [DATA_W-1:0]        wd,
    output logic                     w_en,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]        byp_addr,
    output logic                     byp_hit,
    output logic [DATA_W-1:0]        byp_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] mem_addr_reg [DEPTH];
    logic [DATA_W-1:0] mem_data_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] wa_reg;
    logic [DATA_W-1:0] wd_reg;
    logic              w_en_reg;
    logic              w_en_next;
    logic              push;
    logic              pop;

    // Ready looks only at the registered count, so a full FIFO never accepts
    // even if an entry is being popped in the same cycle.
    assign req_ready = !rst && (count_reg < DEPTH_C);

    // Address 0 is the hardwired zero register: handshake completes but
    // nothing is queued.
    assign push = req_valid && req_ready && (req_addr != '0);

    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

    // Next-state / strobe logic. A pop loads the FIFO head into wa/wd.
    always_comb begin
        state_next = state_reg;
        w_en_next  = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                w_en_next  = 1'b1;
                state_next = STROBE;
            end
            STROBE: begin
                // Chain directly into the next write to sustain 2 cycles/write.
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            w_en_reg   <= 1'b0;
            wa_reg     <= '0;
            wd_reg     <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            w_en_reg  <= w_en_next;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                wa_reg     <= mem_addr_reg[rd_ptr_reg];
                wd_reg     <= wd_next_head();
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    function automatic logic [DATA_W-1:0] wd_next_head();
        return mem_data_reg[rd_ptr_reg];
    endfunction

    // FIFO storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_reg[wr_ptr_reg] <= req_addr;
            mem_data_reg[wr_ptr_reg] <= req_data;
        end
    end

    assign wa    = wa_reg;
    assign wd    = wd_reg;
    assign w_en  = w_en_reg;
    assign count = count_reg;
    assign busy  = (state_reg != IDLE) || (count_reg != '0);

`ifdef WB_BYPASS_EN
    // Slot gi holds the gi-th oldest queued entry; only the first count_reg
    // slots are live.
    logic [DEPTH-1:0] byp_match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_byp
            logic [PTR_W-1:0] slot;
            assign slot          = rd_ptr_reg + PTR_W'(gi);
            assign byp_match[gi] = (CNT_W'(gi) < count_reg) &&
                                   (mem_addr_reg[slot] == byp_addr);
        end
    endgenerate

    // Age order, oldest first: wa/wd in SETUP, then FIFO head..tail. Later
    // matches overwrite earlier ones so the youngest write wins. Once in
    // STROBE the write has already committed and is no longer forwarded.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (byp_addr != '0) begin
            if ((state_reg == SETUP) && (wa_reg == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = wd_reg;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (byp_match[i]) begin
                    byp_hit  = 1'b1;
                    byp_data = mem_data_reg[rd_ptr_reg + PTR_W'(i)];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_sequencer.sv
module tb_reg_writeback_sequencer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              w_en;
    logic [$clog2(DEPTH):0] count;
    logic              busy;
`ifdef WB_BYPASS_EN
    logic [ADDR_W-1:0] byp_addr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
`endif

    always #5 clk = ~clk;

    reg_writeback_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wa        (wa),
        .wd        (wd),
        .w_en      (w_en),
        .count     (count),
        .busy      (busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_addr  (byp_addr),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data)
`endif
    );

    // Register file as the environment sees it: commits on the rising edge of w_en.
    logic [DATA_W-1:0] rf [32];
    always @(posedge w_en) begin
        if (wa != '0) rf[wa] <= wd;
    end

    // Reference model: each accepted write gets a load edge
    // L = max(accept+1, previous L + 2); it sits in wa/wd from L, strobes
    // (commits) at L+1 and stops keeping the block busy at L+2.
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                l;
    } rec_t;

    rec_t              q[$];
    int                t = 0;
    int                last_l = -100;
    logic [ADDR_W-1:0] wa_e = '0;
    logic [DATA_W-1:0] wd_e = '0;
    logic [DATA_W-1:0] rf_m [32];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock,
    // advance the model, check registered outputs.
    task automatic step(input bit v, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit r, output bit acc);
        int  pend;
        int  l;
        bit  exp_w;
        bit  exp_ready;
        rst       = r;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
`ifdef WB_BYPASS_EN
        byp_addr  = (t % 3 == 0) ? 5'd3 : ADDR_W'($urandom_range(0, 15));
`endif
        #1;
        pend = 0;
        foreach (q[i]) if (q[i].l > t) pend++;
        exp_ready = !r && (pend < DEPTH);
        check("req_ready", req_ready, exp_ready);
`ifdef WB_BYPASS_EN
        begin
            bit                h;
            logic [DATA_W-1:0] bd;
            h  = 1'b0;
            bd = '0;
            if (byp_addr != '0)
                foreach (q[i])
                    if (q[i].l >= t && q[i].a == byp_addr) begin h = 1'b1; bd = q[i].d; end
            check("byp_hit", byp_hit, h);
            check("byp_data", byp_data, bd);
        end
`endif
        acc = v && exp_ready;
        @(posedge clk);
        t++;
        if (r) begin
            q.delete();
            last_l = -100;
            wa_e   = '0;
            wd_e   = '0;
        end else begin
            foreach (q[i]) begin
                if (q[i].l == t) begin wa_e = q[i].a; wd_e = q[i].d; end
                if (q[i].l + 1 == t) rf_m[q[i].a] = q[i].d;
            end
            while (q.size() > 0 && q[0].l + 2 <= t) q.delete(0);
            if (acc && a != '0) begin
                l = (t + 1 > last_l + 2) ? t + 1 : last_l + 2;
                last_l = l;
                q.push_back('{a, d, l});
            end
        end
        exp_w = 1'b0;
        pend  = 0;
        foreach (q[i]) begin
            if (q[i].l + 1 == t) exp_w = 1'b1;
            if (q[i].l > t) pend++;
        end
        #1;
        check("w_en", w_en, exp_w);
        check("wa", wa, wa_e);
        check("wd", wd, wd_e);
        check("count", count, 64'(pend));
        check("busy", busy, q.size() != 0);
    endtask

    initial begin
        bit acc;
        int guard;
        int idx;
        for (int i = 0; i < 32; i++) begin rf[i] = '0; rf_m[i] = '0; end
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
`ifdef WB_BYPASS_EN
        byp_addr = '0;
`endif

        // Reset for two cycles, then one idle cycle.
        step(0, 0, 0, 1, acc);
        step(0, 0, 0, 1, acc);
        step(0, 0, 0, 0, acc);

        // Single write with full latency profile.
        step(1, 5'd5, 32'hDEADBEEF, 0, acc);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, acc);
        check("x5", rf[5], 32'hDEADBEEF);

        // Back-to-back stream of 8 writes holding valid until accepted.
        idx = 1;
        guard = 0;
        while (idx <= 8 && guard < 100) begin
            step(1, ADDR_W'(idx), 32'(idx * 32'h11), 0, acc);
            if (acc) idx++;
            guard++;
        end
        check("stream_accepted", 64'(idx), 64'd9);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, acc);
        for (int i = 1; i <= 8; i++) check("stream_rf", rf[i], 32'(i * 32'h11));

        // Writes to x0 are acknowledged and dropped.
        step(1, 5'd0, 32'hFFFFFFFF, 0, acc);
        check("x0_accepted", acc, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, acc);
        check("x0", rf[0], 32'h0);

        // Repeated address: last accepted value wins.
        step(1, 5'd3, 32'h1, 0, acc);
        step(1, 5'd3, 32'h2, 0, acc);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, acc);
        check("x3", rf[3], 32'h2);

        // Reset during the first strobe: only the first write lands.
        step(1, 5'd10, 32'hA0A0A0A0, 0, acc);
        step(1, 5'd11, 32'hB1B1B1B1, 0, acc);
        step(1, 5'd12, 32'hC2C2C2C2, 0, acc);
        step(0, 0, 0, 1, acc);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, acc);
        check("x10", rf[10], 32'hA0A0A0A0);
        check("x11", rf[11], 32'h0);
        check("x12", rf[12], 32'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) < 60), ADDR_W'($urandom_range(0, 31)),
                 $urandom, ($urandom_range(0, 99) < 2), acc);
        end
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, acc);

        for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), rf[i], rf_m[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
